// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a binary source and the bin_to_bcd_seq converter.
// The blank flags exist only when BCD_BLANK_EN is defined.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 9,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;

    modport master (output start, output bin, input busy, input done, input bcd, input blank);
    modport slave  (input start, input bin, output busy, output done, output bcd, output blank);
`else
    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero blank flags are enabled with the BCD_BLANK_EN macro.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 9,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            reset,
    bin_to_bcd_seq_if.slave bus
);

    localparam int SW = 4*DIGITS + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    localparam int BW = 4*DIGITS;

    function automatic longint pow10(input int n);
        longint p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam longint MAX_BIN = (64'd1 << BIN_W) - 64'd1;

    generate
        if (pow10(DIGITS) <= MAX_BIN) begin : g_param_check
            $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    // No carry between nibbles: a digit <= 4 never exceeds 9 after doubling.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] f);
        logic [BW-1:0] r;
        r = f;
        for (int k = 0; k < DIGITS; k++) begin
            if (f[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = f[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = f[4*k +: 4];
            end
        end
        return r;
    endfunction

`ifdef BCD_BLANK_EN
    function automatic logic [DIGITS-1:0] blank_of(input logic [BW-1:0] f);
        logic [DIGITS-1:0] r;
        logic              zero_above;
        r          = {DIGITS{1'b0}};
        zero_above = 1'b1;
        for (int k = DIGITS-1; k >= 1; k--) begin
            zero_above = zero_above & (f[4*k +: 4] == 4'd0);
            r[k]       = zero_above;
        end
        return r;
    endfunction
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [SW-1:0]   sr_r, sr_s;
    logic [SW-1:0]   adj_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic [BW-1:0]   bcd_r, bcd_s;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0] blank_r, blank_s;
`endif

    // Next-state and datapath decode.
    always_comb begin
        state_s = state_r;
        sr_s    = sr_r;
        cnt_s   = cnt_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        bcd_s   = bcd_r;
`ifdef BCD_BLANK_EN
        blank_s = blank_r;
`endif
        adj_s   = {add3(sr_r[SW-1:BIN_W]), sr_r[BIN_W-1:0]};
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    sr_s    = {{BW{1'b0}}, bus.bin};
                    cnt_s   = CW'(BIN_W);
                    busy_s  = 1'b1;
                    state_s = CONV;
                end else begin
                    state_s = IDLE;
                end
            end
            CONV: begin
                sr_s  = {adj_s[SW-2:0], 1'b0};
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_s = LOAD;
                end else begin
                    state_s = CONV;
                end
            end
            LOAD: begin
                bcd_s   = sr_r[SW-1:BIN_W];
`ifdef BCD_BLANK_EN
                blank_s = blank_of(sr_r[SW-1:BIN_W]);
`endif
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            sr_r    <= {SW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= {BW{1'b0}};
`ifdef BCD_BLANK_EN
            blank_r <= {DIGITS{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            bcd_r   <= bcd_s;
`ifdef BCD_BLANK_EN
            blank_r <= blank_s;
`endif
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.bcd   = bcd_r;
`ifdef BCD_BLANK_EN
    assign bus.blank = blank_r;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (default 9-bit input, 3 digits).
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 9;
    localparam int DIGITS = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blank(input string tag, input logic [2:0] exp);
`ifdef BCD_BLANK_EN
        chk({tag, " blank"}, 32'(bus.blank), 32'(exp));
`else
        if (exp === 3'bxxx) $display("unreachable %s", tag);
`endif
    endtask

    // One full conversion started from IDLE; samples on falling edges.
    task automatic run(input string tag, input logic [8:0] v, input logic [11:0] exp, input logic [2:0] exp_blank);
        int          n;
        int          nb;
        int          nchg;
        logic [11:0] prev;
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
        prev      = bus.bcd;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = 9'($urandom);
        n    = 1;
        nb   = 0;
        nchg = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            if (bus.busy === 1'b1) nb++;
            if (bus.bcd !== prev) nchg++;
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd11);
        chk({tag, " busy_cycles"}, 32'(nb), 32'd10);
        chk({tag, " bcd_hold"}, 32'(nchg), 32'd0);
        chk({tag, " bcd"}, 32'(bus.bcd), 32'(exp));
        chk({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
        chk_blank(tag, exp_blank);
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n;
        int nd;
        int nchg;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bin   = 9'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset bcd", 32'(bus.bcd), 32'd0);
        chk_blank("reset", 3'b000);
        reset = 1'b0;

        run("bin0",   9'd0,   12'h000, 3'b110);
        run("bin255", 9'd255, 12'h255, 3'b000);
        run("bin511", 9'd511, 12'h511, 3'b000);
        run("bin100", 9'd100, 12'h100, 3'b000);

        // Start while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 9'd37;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 9'd400;
        @(negedge clk);
        bus.start = 1'b0;
        n = 5;
        while (bus.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("ignore latency", 32'(n), 32'd11);
        chk("ignore bcd", 32'(bus.bcd), 32'h037);
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        chk("ignore single_done", 32'(nd), 32'd0);
        chk("ignore idle busy", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 9'd123;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort bcd", 32'(bus.bcd), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) nd++;
        end
        chk("abort no_done", 32'(nd), 32'd0);
        chk("abort bcd_after", 32'(bus.bcd), 32'd0);
        run("bin123", 9'd123, 12'h123, 3'b000);

        // Start held high: back-to-back conversions every BIN_W+2 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 9'd9;
        n = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first latency", 32'(n), 32'd11);
        chk("b2b first bcd", 32'(bus.bcd), 32'h009);
        bus.bin = 9'd10;
        n    = 0;
        nchg = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.done !== 1'b1 && bus.bcd !== 12'h009) nchg++;
        end while (bus.done !== 1'b1 && n < 30);
        bus.start = 1'b0;
        chk("b2b period", 32'(n), 32'd11);
        chk("b2b hold", 32'(nchg), 32'd0);
        chk("b2b second bcd", 32'(bus.bcd), 32'h010);
        repeat (3) @(negedge clk);
        chk("b2b idle busy", 32'(bus.busy), 32'd0);

        run("bin7",   9'd7,   12'h007, 3'b110);
        run("bin42",  9'd42,  12'h042, 3'b100);
        run("bin305", 9'd305, 12'h305, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
